// File: rtl/burst_reader.sv
// burst_reader: streams PSRAM bytes to the debug bus, one byte per strobe, via a burst line buffer
//
// Ports:
//   i_clk                 system clock (memory controller clk_out domain)
//   i_sys_resetn          synchronous active-low reset
//   i_ptr_reset           pulse: address/byte pointer to 0, buffer invalidated, flags cleared
//   i_strobe              pulse: request next byte
//   o_data                returned byte, meaningful while o_data_valid=1, held otherwise
//   o_data_valid          one-cycle pulse per served byte
//   o_busy                high while a fetch or drain is in progress
//   o_error               sticky: a fetch timed out
//   o_overrun             sticky: a strobe arrived while busy and was dropped
//   o_mem_addr            burst start address (16-bit word addressing)
//   o_mem_cmd             command type, always read (0)
//   o_mem_cmd_en          one-cycle command pulse, issued in the cycle i_mem_ready is seen
//   i_mem_ready           controller/arbiter can accept a command
//   i_mem_rd_data         read beat, little-endian bytes
//   i_mem_rd_data_valid   beat qualifier
module burst_reader #(
    parameter int BEATS     = 4,
    parameter int ADDR_STEP = 16,
    parameter int TIMEOUT   = 63
) (
    input  logic        i_clk,
    input  logic        i_sys_resetn,
    input  logic        i_ptr_reset,
    input  logic        i_strobe,
    output logic [7:0]  o_data,
    output logic        o_data_valid,
    output logic        o_busy,
    output logic        o_error,
    output logic        o_overrun,
    output logic [20:0] o_mem_addr,
    output logic        o_mem_cmd,
    output logic        o_mem_cmd_en,
    input  logic        i_mem_ready,
    input  logic [63:0] i_mem_rd_data,
    input  logic        i_mem_rd_data_valid
);
    localparam int NBYTES = 8 * BEATS;
    localparam int IW     = $clog2(NBYTES);
    localparam int BW     = IW - 3;
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NBYTES - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [NBYTES-1:0][7:0] r_buf;
    logic [IW-1:0]          r_idx;
    logic [BW-1:0]          r_beat_cnt;
    logic [TW-1:0]          r_tmo;
    logic                   r_buf_valid;
    logic [7:0]             r_data;
    logic                   r_data_valid;
    logic                   r_error;
    logic                   r_overrun;
    logic [20:0]            r_mem_addr;
    logic                   w_idle_req;
    logic                   w_hit;
    logic                   w_miss;
    logic                   w_in_fetch;
    logic                   w_last_beat;
    logic                   w_tmo_hit;
    logic [7:0]             w_byte0;

    // A strobe coinciding with ptr_reset is swallowed entirely.
    assign w_idle_req  = (r_state == S_IDLE) && i_strobe && !i_ptr_reset;
    assign w_hit       = w_idle_req && r_buf_valid;
    assign w_miss      = w_idle_req && !r_buf_valid;
    assign w_in_fetch  = (r_state == S_WAIT) || (r_state == S_DRAIN);
    assign w_last_beat = i_mem_rd_data_valid && (r_beat_cnt == LAST_BEAT);
    assign w_tmo_hit   = !i_mem_rd_data_valid && (r_tmo == TMO_LAST);
    // Byte 0 of the burst lives in beat 0, which is only still on the bus for single-beat bursts.
    assign w_byte0     = (r_beat_cnt == '0) ? i_mem_rd_data[7:0] : r_buf[0];

    assign o_data       = r_data;
    assign o_data_valid = r_data_valid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_error      = r_error;
    assign o_overrun    = r_overrun;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_cmd    = 1'b0;
    assign o_mem_cmd_en = (r_state == S_REQ) && i_mem_ready && !i_ptr_reset;

    always_ff @(posedge i_clk) begin
        if (!i_sys_resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_miss ? S_REQ : S_IDLE;
            S_REQ:   w_next = i_ptr_reset ? S_IDLE : (i_mem_ready ? S_WAIT : S_REQ);
            // ptr_reset mid-fetch must still absorb the outstanding beats, unless this was the last one.
            S_WAIT:  w_next = (w_last_beat || w_tmo_hit) ? S_IDLE : (i_ptr_reset ? S_DRAIN : S_WAIT);
            S_DRAIN: w_next = (w_last_beat || w_tmo_hit) ? S_IDLE : S_DRAIN;
            default: w_next = S_IDLE;
        endcase
    end

    // Line buffer has no reset: r_buf_valid guards every read.
    always_ff @(posedge i_clk) begin
        if (r_state == S_WAIT && i_mem_rd_data_valid && !i_ptr_reset) begin
            for (int k = 0; k < 8; k++)
                r_buf[{r_beat_cnt, 3'(k)}] <= i_mem_rd_data[8*k +: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_sys_resetn) begin
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_error      <= 1'b0;
            r_overrun    <= 1'b0;
            r_mem_addr   <= '0;
            r_idx        <= '0;
            r_buf_valid  <= 1'b0;
            r_beat_cnt   <= '0;
            r_tmo        <= '0;
        end else begin
            r_data_valid <= 1'b0;
            r_tmo        <= (w_in_fetch && !i_mem_rd_data_valid) ? r_tmo + 1'b1 : '0;
            // The beat count survives ptr_reset so a drain knows how many beats are still owed.
            r_beat_cnt   <= (!w_in_fetch || w_last_beat) ? '0 :
                            i_mem_rd_data_valid ? r_beat_cnt + 1'b1 : r_beat_cnt;
            if (i_ptr_reset) begin
                r_mem_addr  <= '0;
                r_idx       <= '0;
                r_buf_valid <= 1'b0;
                r_error     <= 1'b0;
                r_overrun   <= 1'b0;
            end else begin
                if (i_strobe && r_state != S_IDLE)
                    r_overrun <= 1'b1;
                if (w_hit) begin
                    r_data       <= r_buf[r_idx];
                    r_data_valid <= 1'b1;
                    r_idx        <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_buf_valid <= 1'b0;
                        r_mem_addr  <= r_mem_addr + 21'(ADDR_STEP);
                    end
                end
                // The strobe that caused the miss is answered with byte 0 of the fresh line.
                if (r_state == S_WAIT && w_last_beat) begin
                    r_data       <= w_byte0;
                    r_data_valid <= 1'b1;
                    r_idx        <= IW'(1);
                    r_buf_valid  <= 1'b1;
                end
                if (r_state == S_WAIT && w_tmo_hit) begin
                    r_error     <= 1'b1;
                    r_buf_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_burst_reader.sv
// tb_burst_reader: directed self-checking bench for burst_reader
module tb_burst_reader;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ptr_reset = 1'b0;
    logic        strobe = 1'b0;
    logic [7:0]  data;
    logic        data_valid;
    logic        busy;
    logic        error;
    logic        overrun;
    logic [20:0] mem_addr;
    logic        mem_cmd;
    logic        mem_cmd_en;
    logic        mem_ready = 1'b1;
    logic [63:0] rd_data = '0;
    logic        rd_valid = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int n_cmd = 0;
    int n_dv  = 0;

    burst_reader dut (
        .i_clk(clk),
        .i_sys_resetn(resetn),
        .i_ptr_reset(ptr_reset),
        .i_strobe(strobe),
        .o_data(data),
        .o_data_valid(data_valid),
        .o_busy(busy),
        .o_error(error),
        .o_overrun(overrun),
        .o_mem_addr(mem_addr),
        .o_mem_cmd(mem_cmd),
        .o_mem_cmd_en(mem_cmd_en),
        .i_mem_ready(mem_ready),
        .i_mem_rd_data(rd_data),
        .i_mem_rd_data_valid(rd_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_cmd_en) n_cmd <= n_cmd + 1;
        if (data_valid) n_dv <= n_dv + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed hang, required finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory image: byte at word address a, burst byte offset o is (2*a + o) mod 256.
    function automatic logic [63:0] word(input logic [20:0] a, input int b);
        logic [63:0] w;
        int base;
        base = int'(a) * 2 + 8 * b;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(base + k);
        return w;
    endfunction

    task automatic beats(input logic [20:0] a, input int from, input int n);
        for (int b = from; b < from + n; b++) begin
            rd_valid = 1'b1;
            rd_data  = word(a, b);
            cyc();
        end
        rd_valid = 1'b0;
    endtask

    initial begin
        int k;
        int snap;
        cyc();
        cyc();
        chk("rst_data", data, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_cmd_en", mem_cmd_en, 0);
        chk("rst_cmd", mem_cmd, 0);
        resetn = 1'b1;
        cyc();

        // first miss: fetch addr 0
        strobe = 1'b1;
        cyc();
        strobe = 1'b0;
        chk("miss_busy", busy, 1);
        chk("miss_cmd_en", mem_cmd_en, 1);
        chk("miss_addr", mem_addr, 0);
        cyc();
        chk("wait_cmd_en", mem_cmd_en, 0);
        cyc();
        cyc();
        beats(21'd0, 0, 4);
        chk("fill_dv", data_valid, 1);
        chk("fill_data", data, 8'h00);
        chk("fill_busy", busy, 0);
        cyc();
        chk("fill_dv_pulse", data_valid, 0);
        chk("fill_data_hold", data, 8'h00);

        // 31 hits spaced 2 cycles
        for (int i = 1; i < 32; i++) begin
            strobe = 1'b1;
            cyc();
            strobe = 1'b0;
            chk($sformatf("hit%0d_dv", i), data_valid, 1);
            chk($sformatf("hit%0d_data", i), data, 64'(i));
            cyc();
            chk($sformatf("hit%0d_dv_off", i), data_valid, 0);
        end
        chk("hits_cmd_count", 64'(n_cmd), 1);
        chk("hits_dv_count", 64'(n_dv), 32);
        chk("hits_busy", busy, 0);
        chk("wrap_addr", mem_addr, 16);

        // 33rd strobe refetches at addr 16
        strobe = 1'b1;
        cyc();
        strobe = 1'b0;
        chk("refetch_cmd_en", mem_cmd_en, 1);
        chk("refetch_addr", mem_addr, 16);
        cyc();
        snap = n_dv;
        strobe = 1'b1;
        cyc();
        strobe = 1'b0;
        chk("ovr_flag", overrun, 1);
        chk("ovr_dv", data_valid, 0);
        chk("ovr_busy", busy, 1);

        // ptr_reset after 2 of 4 beats -> drain the remaining 2
        beats(21'd16, 0, 2);
        ptr_reset = 1'b1;
        cyc();
        ptr_reset = 1'b0;
        chk("prst_overrun", overrun, 0);
        chk("prst_addr", mem_addr, 0);
        chk("prst_busy", busy, 1);
        beats(21'd16, 2, 1);
        chk("drain3_busy", busy, 1);
        beats(21'd16, 3, 1);
        chk("drain4_busy", busy, 0);
        chk("drain4_dv", data_valid, 0);
        cyc();
        chk("drain_dv_count", 64'(n_dv), 64'(snap));

        // buffer invalid: next strobe fetches addr 0 again
        strobe = 1'b1;
        cyc();
        strobe = 1'b0;
        chk("post_drain_cmd_en", mem_cmd_en, 1);
        chk("post_drain_addr", mem_addr, 0);
        cyc();
        beats(21'd0, 0, 4);
        chk("post_drain_dv", data_valid, 1);
        chk("post_drain_data", data, 8'h00);

        // back-to-back strobes consume bytes 1..31
        strobe = 1'b1;
        repeat (31) cyc();
        strobe = 1'b0;
        chk("b2b_dv", data_valid, 1);
        chk("b2b_last_data", data, 8'h1F);
        chk("b2b_addr", mem_addr, 16);
        cyc();

        // timeout: no beats returned
        strobe = 1'b1;
        cyc();
        strobe = 1'b0;
        chk("tmo_cmd_en", mem_cmd_en, 1);
        chk("tmo_addr", mem_addr, 16);
        cyc();
        repeat (60) cyc();
        chk("tmo_early_error", error, 0);
        chk("tmo_early_busy", busy, 1);
        k = 0;
        while (!error && k < 10) begin
            cyc();
            k++;
        end
        chk("tmo_cycles", 64'(k), 3);
        chk("tmo_error", error, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_addr_kept", mem_addr, 16);

        // retry reissues same address, error stays sticky
        strobe = 1'b1;
        cyc();
        strobe = 1'b0;
        chk("retry_cmd_en", mem_cmd_en, 1);
        chk("retry_addr", mem_addr, 16);
        chk("retry_error_sticky", error, 1);
        cyc();
        beats(21'd16, 0, 4);
        chk("retry_dv", data_valid, 1);
        chk("retry_data", data, 8'h20);

        // simultaneous strobe and ptr_reset with a valid buffer
        strobe = 1'b1;
        ptr_reset = 1'b1;
        cyc();
        strobe = 1'b0;
        ptr_reset = 1'b0;
        chk("simul_dv", data_valid, 0);
        chk("simul_overrun", overrun, 0);
        chk("simul_error", error, 0);
        chk("simul_addr", mem_addr, 0);
        chk("simul_busy", busy, 0);

        // mem_ready held low in REQ: no timeout there
        mem_ready = 1'b0;
        strobe = 1'b1;
        cyc();
        strobe = 1'b0;
        snap = n_cmd;
        repeat (70) cyc();
        chk("rdy_low_cmd_en", mem_cmd_en, 0);
        chk("rdy_low_cmd_count", 64'(n_cmd), 64'(snap));
        chk("rdy_low_busy", busy, 1);
        chk("rdy_low_error", error, 0);
        mem_ready = 1'b1;
        #1;
        chk("rdy_high_cmd_en", mem_cmd_en, 1);
        chk("rdy_high_addr", mem_addr, 0);
        cyc();
        beats(21'd0, 0, 1);
        chk("mid_wait_busy", busy, 1);

        // reset mid-WAIT
        resetn = 1'b0;
        cyc();
        chk("midrst_data", data, 0);
        chk("midrst_dv", data_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_error", error, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_cmd_en", mem_cmd_en, 0);
        resetn = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
